// File: rtl/vsub_pkg.sv
// Shared definitions for the multicycle packed-vector subtractor (vsub_seq).
// The optional feature macro VSUB_SAT_EN (saturating subtract) is honoured in vsub_lane.
package vsub_pkg;

    // Default vector geometry: LANES lanes of LANE_W bits each.
    localparam int unsigned LANES_DEFAULT  = 4;
    localparam int unsigned LANE_W_DEFAULT = 8;

    // Lane index width for the default geometry.
    localparam int unsigned IDX_W = $clog2(LANES_DEFAULT);

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlag,
        StDone
    } state_e;

endpackage

// File: rtl/vsub_lane.sv
// Combinational single-lane subtract returning {borrow, diff}.
// With VSUB_SAT_EN defined, a borrowing lane clamps to zero; borrow is still reported.
module vsub_lane #(
    parameter int unsigned LANE_W = 8
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] diff_o,
    output logic              borrow_o
);

    logic [LANE_W:0] wide_diff;

    // Extra top bit of the widened subtract is the unsigned borrow.
    always_comb begin
        wide_diff = {1'b0, a_i} - {1'b0, b_i};
        borrow_o  = wide_diff[LANE_W];
`ifdef VSUB_SAT_EN
        diff_o = wide_diff[LANE_W] ? '0 : wide_diff[LANE_W-1:0];
`else
        diff_o = wide_diff[LANE_W-1:0];
`endif
    end

endmodule

// File: rtl/vsub_seq.sv
// Multicycle packed-vector subtractor: one lane per clock, then a flag cycle, then a done pulse.
// Optional feature macro: VSUB_SAT_EN (unsigned saturating subtract, N forced to 0).
module vsub_seq
    import vsub_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEFAULT,
    parameter int unsigned LANE_W = LANE_W_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LANES*LANE_W-1:0] in1,
    input  logic [LANES*LANE_W-1:0] in2,
    output logic [LANES*LANE_W-1:0] out,
    output logic [LANES-1:0]        borrow,
    output logic                    N,
    output logic                    Z,
    output logic                    busy,
    output logic                    done
);

    // Derived locally so a non-default LANES still gets a correctly sized counter.
    localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VecW = LANES * LANE_W;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q;
    logic [VecW-1:0]   opa_q, opb_q, out_q;
    logic [LANES-1:0]  borrow_q;
    logic              n_q, z_q;
    logic              accept, last_lane;
    logic [LANE_W-1:0] lane_a, lane_b, lane_diff;
    logic              lane_borrow;
    logic              n_next, z_next;

    // A start is taken in IDLE and also in DONE, which allows back-to-back operations.
    assign accept    = start & ((state_q == StIdle) | (state_q == StDone));
    assign last_lane = (idx_q == IdxW'(LANES - 1));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = accept ? StRun : StIdle;
            StRun:   state_d = last_lane ? StFlag : StRun;
            StFlag:  state_d = StDone;
            StDone:  state_d = accept ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy = (state_q == StRun) | (state_q == StFlag);
        done = (state_q == StDone);
    end

    // Select the current lane of each latched operand.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (idx_q == IdxW'(i)) begin
                lane_a = opa_q[i*LANE_W +: LANE_W];
                lane_b = opb_q[i*LANE_W +: LANE_W];
            end
        end
    end

    vsub_lane #(
        .LANE_W (LANE_W)
    ) u_lane (
        .a_i      (lane_a),
        .b_i      (lane_b),
        .diff_o   (lane_diff),
        .borrow_o (lane_borrow)
    );

    // Result flags from the completed out register.
    always_comb begin
        n_next = 1'b0;
`ifndef VSUB_SAT_EN
        for (int i = 0; i < int'(LANES); i++) begin
            n_next = n_next | out_q[i*LANE_W + LANE_W - 1];
        end
`endif
        z_next = (out_q == '0);
    end

    // Datapath: operand latch, lane write-back, index counter and flag capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            out_q    <= '0;
            borrow_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else if (accept) begin
            idx_q    <= '0;
            opa_q    <= in1;
            opb_q    <= in2;
            out_q    <= '0;
            borrow_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else if (state_q == StRun) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (idx_q == IdxW'(i)) begin
                    out_q[i*LANE_W +: LANE_W] <= lane_diff;
                    borrow_q[i]               <= lane_borrow;
                end
            end
            if (!last_lane) begin
                idx_q <= idx_q + IdxW'(1);
            end
        end else if (state_q == StFlag) begin
            n_q <= n_next;
            z_q <= z_next;
        end
    end

    assign out    = out_q;
    assign borrow = borrow_q;
    assign N      = n_q;
    assign Z      = z_q;

endmodule

// File: tb/tb_vsub_seq.sv
// Directed self-checking bench for vsub_seq; expectations follow VSUB_SAT_EN when defined.
module tb_vsub_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] out;
    logic [3:0]  borrow;
    logic        n_flag;
    logic        z_flag;
    logic        busy;
    logic        done;

    int vectors;
    int errors;

    vsub_seq dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .out    (out),
        .borrow (borrow),
        .N      (n_flag),
        .Z      (z_flag),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a one-cycle start; returns in cycle t+1.
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        in1   = a;
        in2   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count ticks until done is seen (0 if already high); 99 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        if (!done) n = 99;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        in1   = 32'h1234_5678;
        in2   = 32'h0101_0101;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (done !== 1'b0) begin
                $display("FAIL reset_done: got %b need 0", done);
                errors++;
            end
        end
        vectors++;
        if ({out, borrow, n_flag, z_flag, busy} !== 40'h0) begin
            $display("FAIL reset_outputs: got out=%h borrow=%h N=%b Z=%b busy=%b need all 0",
                     out, borrow, n_flag, z_flag, busy);
            errors++;
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_idle: got busy=%b done=%b need 0 0", busy, done);
            errors++;
        end
    endtask

    task automatic test_basic();
        pulse_start(32'h0A14_1E28, 32'h0102_0304);
        for (int k = 1; k <= 6; k++) begin
            vectors++;
            if (busy !== (k <= 5) || done !== (k == 6)) begin
                $display("FAIL basic_handshake t+%0d: got busy=%b done=%b need %b %b",
                         k, busy, done, (k <= 5), (k == 6));
                errors++;
            end
            if (k == 2) begin
                vectors++;
                if (out !== 32'h0000_0024) begin
                    $display("FAIL basic_partial: got %h need 00000024", out);
                    errors++;
                end
            end
            if (k < 6) tick();
        end
        vectors++;
        if (out !== 32'h0912_1B24 || borrow !== 4'h0 || n_flag !== 1'b0 || z_flag !== 1'b0) begin
            $display("FAIL basic_result: got out=%h borrow=%h N=%b Z=%b need 09121b24 0 0 0",
                     out, borrow, n_flag, z_flag);
            errors++;
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            $display("FAIL basic_done_pulse: got %b need 0", done);
            errors++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e_out;
        logic        e_n, e_z;
        int          n;
        pulse_start(32'h0000_0000, 32'h0101_0101);
        wait_done(n);
`ifdef VSUB_SAT_EN
        e_out = 32'h0000_0000; e_n = 1'b0; e_z = 1'b1;
`else
        e_out = 32'hFFFF_FFFF; e_n = 1'b1; e_z = 1'b0;
`endif
        vectors++;
        if (n !== 5 || out !== e_out || borrow !== 4'hF || n_flag !== e_n || z_flag !== e_z) begin
            $display("FAIL wrap_all: got lat=%0d out=%h borrow=%h N=%b Z=%b need 5 %h f %b %b",
                     n, out, borrow, n_flag, z_flag, e_out, e_n, e_z);
            errors++;
        end
        tick();
        pulse_start(32'h80FF_0001, 32'h0001_0203);
        wait_done(n);
`ifdef VSUB_SAT_EN
        e_out = 32'h80FE_0000; e_n = 1'b0; e_z = 1'b0;
`else
        e_out = 32'h80FE_FEFE; e_n = 1'b1; e_z = 1'b0;
`endif
        vectors++;
        if (n !== 5 || out !== e_out || borrow !== 4'h3 || n_flag !== e_n || z_flag !== e_z) begin
            $display("FAIL wrap_mixed: got lat=%0d out=%h borrow=%h N=%b Z=%b need 5 %h 3 %b %b",
                     n, out, borrow, n_flag, z_flag, e_out, e_n, e_z);
            errors++;
        end
        tick();
    endtask

    task automatic test_operand_hold();
        int n;
        pulse_start(32'h5A5A_5A5A, 32'h5A5A_5A5A);
        tick();
        in1 = 32'hFFFF_FFFF;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL hold_busy: got %b need 1", busy);
            errors++;
        end
        wait_done(n);
        vectors++;
        if (n !== 2 || out !== 32'h0 || borrow !== 4'h0 || n_flag !== 1'b0 || z_flag !== 1'b1) begin
            $display("FAIL hold_result: got lat=%0d out=%h borrow=%h N=%b Z=%b need 2 0 0 0 1",
                     n, out, borrow, n_flag, z_flag);
            errors++;
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL hold_not_queued: got busy=%b done=%b need 0 0", busy, done);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e_out;
        logic        e_n, e_z;
        int          n;
        in1   = 32'h1020_3040;
        in2   = 32'h0101_0101;
        start = 1'b1;
        tick();
        in1 = 32'h0000_0005;
        in2 = 32'h0000_0007;
        wait_done(n);
        vectors++;
        if (n !== 5 || out !== 32'h0F1F_2F3F || borrow !== 4'h0 || n_flag !== 1'b0
            || z_flag !== 1'b0) begin
            $display("FAIL b2b_first: got lat=%0d out=%h borrow=%h N=%b Z=%b need 5 0f1f2f3f 0 0 0",
                     n, out, borrow, n_flag, z_flag);
            errors++;
        end
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || out !== 32'h0) begin
            $display("FAIL b2b_no_gap: got busy=%b done=%b out=%h need 1 0 00000000",
                     busy, done, out);
            errors++;
        end
        wait_done(n);
`ifdef VSUB_SAT_EN
        e_out = 32'h0000_0000; e_n = 1'b0; e_z = 1'b1;
`else
        e_out = 32'h0000_00FE; e_n = 1'b1; e_z = 1'b0;
`endif
        vectors++;
        if (n !== 5 || out !== e_out || borrow !== 4'h1 || n_flag !== e_n || z_flag !== e_z) begin
            $display("FAIL b2b_second: got lat=%0d out=%h borrow=%h N=%b Z=%b need 5 %h 1 %b %b",
                     n, out, borrow, n_flag, z_flag, e_out, e_n, e_z);
            errors++;
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] e_out;
        logic        e_n;
        int          n;
        pulse_start(32'h0A14_1E28, 32'h0102_0304);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({out, borrow, n_flag, z_flag, busy, done} !== 41'h0) begin
            $display("FAIL abort_outputs: got out=%h borrow=%h N=%b Z=%b busy=%b done=%b need 0",
                     out, borrow, n_flag, z_flag, busy, done);
            errors++;
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL abort_idle: got busy=%b done=%b need 0 0", busy, done);
            errors++;
        end
        pulse_start(32'hFF00_FF00, 32'h0F0F_0F0F);
        wait_done(n);
`ifdef VSUB_SAT_EN
        e_out = 32'hF000_F000; e_n = 1'b0;
`else
        e_out = 32'hF0F1_F0F1; e_n = 1'b1;
`endif
        vectors++;
        if (n !== 5 || out !== e_out || borrow !== 4'h5 || n_flag !== e_n || z_flag !== 1'b0) begin
            $display("FAIL abort_rerun: got lat=%0d out=%h borrow=%h N=%b Z=%b need 5 %h 5 %b 0",
                     n, out, borrow, n_flag, z_flag, e_out, e_n);
            errors++;
        end
        tick();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        in1     = '0;
        in2     = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_operand_hold();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
